// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state encoding and address field helpers for dcache_sa_wb
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL,
        ST_FLUSH_SCAN,
        ST_FLUSH_WB
    } state_t;

    // Addresses are handled at 64 bits here and narrowed by the caller.
    function automatic logic [63:0] addr_word(input logic [63:0] a, input int off_bits);
        return (a & ((64'd1 << off_bits) - 64'd1)) >> 2;
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] a, input int off_bits,
                                               input int idx_bits);
        return (a >> off_bits) & ((64'd1 << idx_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] a, input int off_bits,
                                             input int idx_bits);
        return a >> (off_bits + idx_bits);
    endfunction

    function automatic logic [63:0] line_base(input logic [63:0] a, input int off_bits);
        return a & ~((64'd1 << off_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] make_addr(input logic [63:0] tag, input logic [63:0] index,
                                              input logic [63:0] word, input int off_bits,
                                              input int idx_bits);
        return (tag << (off_bits + idx_bits)) | (index << off_bits) | (word << 2);
    endfunction

endpackage

// File: rtl/dcache_way_store.sv
// rtl/dcache_way_store.sv - one cache way: tag, valid, dirty and data arrays with a combinational read port
module dcache_way_store #(
    parameter int SETS       = 32,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 23,
    parameter int IDX_W      = 5,
    parameter int WOFF_W     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  index,
    input  logic [WOFF_W-1:0] word,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic              valid,
    output logic              dirty,
    output logic [TAG_W-1:0]  tag,
    output logic [31:0]       rdata,
    input  logic              fill,
    input  logic [31:0]       fill_data,
    input  logic              install,
    input  logic [TAG_W-1:0]  install_tag,
    input  logic              store,
    input  logic [3:0]        strobe,
    input  logic [31:0]       store_data,
    input  logic              clean
);

    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS][LINE_WORDS];
    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;

    // Tag and data arrays carry no reset so they can map onto RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (fill) begin
                data_mem[index][word] <= fill_data;
            end else if (store) begin
                for (int b = 0; b < 4; b++) begin
                    if (strobe[b]) begin
                        data_mem[index][word][8*b +: 8] <= store_data[8*b +: 8];
                    end
                end
            end
            if (install) begin
                tag_mem[index] <= install_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (install) begin
                valid_q[index] <= 1'b1;
                dirty_q[index] <= 1'b0;
            end
            if (store && (strobe != 4'b0000)) begin
                dirty_q[index] <= 1'b1;
            end
            if (clean) begin
                dirty_q[index] <= 1'b0;
            end
        end
    end

    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign tag   = tag_mem[index];
    assign rdata = data_mem[index][word];
    assign hit   = valid && (tag == lookup_tag);

endmodule

// File: rtl/dcache_sa_wb.sv
// rtl/dcache_sa_wb.sv - N-way set-associative write-back write-allocate data cache with flush
module dcache_sa_wb
    import dcache_pkg::*;
#(
    parameter int CACHE_SIZE = 1024,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read_request,
    input  logic                  write_request,
    input  logic [3:0]            write_strobe,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           write_data,
    output logic                  response,
    output logic [31:0]           read_data,
    input  logic                  flush_request,
    output logic                  flush_done,
    output logic                  memory_read_request,
    output logic                  memory_write_request,
    input  logic                  memory_response,
    output logic [ADDR_WIDTH-1:0] memory_addr,
    input  logic [31:0]           memory_read_data,
    output logic [31:0]           memory_write_data
);

    localparam int SETS     = CACHE_SIZE / (4 * LINE_WORDS * WAYS);
    localparam int OFF_BITS = $clog2(4 * LINE_WORDS);
    localparam int IDX_BITS = $clog2(SETS);
    localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int WB_BITS  = $clog2(LINE_WORDS);
    localparam int WOFF_W   = (WB_BITS > 0) ? WB_BITS : 1;
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int WAY_W    = (WAY_BITS > 0) ? WAY_BITS : 1;
    localparam int TAG_W    = ADDR_WIDTH - OFF_BITS - IDX_BITS;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_data;
    logic [3:0]            req_strobe;
    logic                  req_write;
    logic [WOFF_W-1:0]     cnt;
    logic [WAY_W-1:0]      victim_way;
    logic [IDX_W-1:0]      fset;
    logic [WAY_W-1:0]      fway;
    logic [WAY_W-1:0]      rr [SETS];

    logic [63:0]        req_addr64;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_index;
    logic [WOFF_W-1:0]  req_word;
    logic [IDX_W-1:0]   cur_index;
    logic [WOFF_W-1:0]  cur_word;

    logic [WAYS-1:0]  way_hit, way_valid, way_dirty;
    logic [WAYS-1:0]  way_fill, way_install, way_store, way_clean;
    logic [TAG_W-1:0] way_tag   [WAYS];
    logic [31:0]      way_rdata [WAYS];

    logic                  hit_any;
    logic [31:0]           hit_rdata;
    logic [WAY_W-1:0]      miss_victim;
    logic                  miss_dirty;
    logic                  scan_dirty;
    logic                  flush_last;
    logic                  mem_done;
    logic                  last_word;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [ADDR_WIDTH-1:0] refill_addr;

    assign req_addr64 = {{(64-ADDR_WIDTH){1'b0}}, req_addr};
    assign req_tag    = TAG_W'(addr_tag(req_addr64, OFF_BITS, IDX_BITS));
    assign req_index  = IDX_W'(addr_index(req_addr64, OFF_BITS, IDX_BITS));
    assign req_word   = WOFF_W'(addr_word(req_addr64, OFF_BITS));

    assign cur_index = (state == ST_FLUSH_SCAN || state == ST_FLUSH_WB) ? fset : req_index;
    assign cur_word  = (state == ST_LOOKUP) ? req_word : cnt;

    assign mem_done   = memory_response && (memory_read_request || memory_write_request);
    assign last_word  = (cnt == WOFF_W'(LINE_WORDS - 1));
    assign flush_last = (fset == IDX_W'(SETS - 1)) && (fway == WAY_W'(WAYS - 1));
    assign hit_any    = |way_hit;
    assign miss_dirty = way_valid[miss_victim] && way_dirty[miss_victim];
    assign scan_dirty = way_valid[fway] && way_dirty[fway];

    assign wb_addr = ADDR_WIDTH'(make_addr(64'(way_tag[victim_way]), 64'(cur_index), 64'(cnt),
                                           OFF_BITS, IDX_BITS));
    assign refill_addr = ADDR_WIDTH'(line_base(req_addr64, OFF_BITS) | (64'(cnt) << 2));

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_way_store #(
            .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W), .IDX_W(IDX_W), .WOFF_W(WOFF_W)
        ) u_way (
            .clk(clk),
            .reset(reset),
            .index(cur_index),
            .word(cur_word),
            .lookup_tag(req_tag),
            .hit(way_hit[w]),
            .valid(way_valid[w]),
            .dirty(way_dirty[w]),
            .tag(way_tag[w]),
            .rdata(way_rdata[w]),
            .fill(way_fill[w]),
            .fill_data(memory_read_data),
            .install(way_install[w]),
            .install_tag(req_tag),
            .store(way_store[w]),
            .strobe(req_strobe),
            .store_data(req_data),
            .clean(way_clean[w])
        );
    end

    always_comb begin
        hit_rdata = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_rdata |= way_rdata[w];
        end
    end

    // Lowest-index invalid way wins; otherwise fall back to the set's round-robin pointer.
    always_comb begin
        miss_victim = rr[cur_index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) miss_victim = WAY_W'(w);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        way_fill    = '0;
        way_install = '0;
        way_store   = '0;
        way_clean   = '0;
        case (state)
            ST_IDLE: begin
                if (flush_request)                       state_next = ST_FLUSH_SCAN;
                else if (write_request || read_request)  state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (hit_any) begin
                    state_next = ST_IDLE;
                    if (req_write) way_store = way_hit;
                end else begin
                    state_next = miss_dirty ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                if (mem_done && last_word) begin
                    way_clean[victim_way] = 1'b1;
                    state_next = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem_done) begin
                    way_fill[victim_way] = 1'b1;
                    if (last_word) begin
                        way_install[victim_way] = 1'b1;
                        state_next = ST_LOOKUP;
                    end
                end
            end
            ST_FLUSH_SCAN: begin
                if (scan_dirty)      state_next = ST_FLUSH_WB;
                else if (flush_last) state_next = ST_IDLE;
            end
            ST_FLUSH_WB: begin
                if (mem_done && last_word) begin
                    way_clean[victim_way] = 1'b1;
                    state_next = flush_last ? ST_IDLE : ST_FLUSH_SCAN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_addr             <= '0;
            req_data             <= '0;
            req_strobe           <= '0;
            req_write            <= 1'b0;
            cnt                  <= '0;
            victim_way           <= '0;
            fset                 <= '0;
            fway                 <= '0;
            response             <= 1'b0;
            read_data            <= '0;
            flush_done           <= 1'b0;
            memory_read_request  <= 1'b0;
            memory_write_request <= 1'b0;
            memory_addr          <= '0;
            memory_write_data    <= '0;
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else begin
            response   <= 1'b0;
            flush_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (flush_request) begin
                        fset <= '0;
                        fway <= '0;
                    end else if (write_request || read_request) begin
                        req_addr   <= addr;
                        req_data   <= write_data;
                        req_strobe <= write_strobe;
                        req_write  <= write_request;
                    end
                end
                ST_LOOKUP: begin
                    if (hit_any) begin
                        response  <= 1'b1;
                        read_data <= hit_rdata;
                    end else begin
                        victim_way <= miss_victim;
                        cnt        <= '0;
                    end
                end
                ST_WRITEBACK, ST_FLUSH_WB: begin
                    if (mem_done) begin
                        memory_write_request <= 1'b0;
                        cnt <= last_word ? '0 : cnt + 1'b1;
                        if (state == ST_FLUSH_WB && last_word) begin
                            if (flush_last) flush_done <= 1'b1;
                            if (fway == WAY_W'(WAYS - 1)) begin
                                fway <= '0;
                                fset <= fset + 1'b1;
                            end else begin
                                fway <= fway + 1'b1;
                            end
                        end
                    end else if (!memory_write_request) begin
                        // The low cycle after each completion is the inter-word gap.
                        memory_write_request <= 1'b1;
                        memory_addr          <= wb_addr;
                        memory_write_data    <= way_rdata[victim_way];
                    end
                end
                ST_REFILL: begin
                    if (mem_done) begin
                        memory_read_request <= 1'b0;
                        cnt <= last_word ? '0 : cnt + 1'b1;
                        if (last_word) begin
                            rr[req_index] <= (WAYS == 1) ? '0 : rr[req_index] + 1'b1;
                        end
                    end else if (!memory_read_request) begin
                        memory_read_request <= 1'b1;
                        memory_addr         <= refill_addr;
                    end
                end
                ST_FLUSH_SCAN: begin
                    if (scan_dirty) begin
                        victim_way <= fway;
                        cnt        <= '0;
                    end else begin
                        if (flush_last) flush_done <= 1'b1;
                        if (fway == WAY_W'(WAYS - 1)) begin
                            fway <= '0;
                            fset <= fset + 1'b1;
                        end else begin
                            fway <= fway + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_sa_wb.sv
// tb/tb_dcache_sa_wb.sv - directed self-checking bench for dcache_sa_wb with a word memory model
module tb_dcache_sa_wb;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
    } mem_op_t;

    logic        clk;
    logic        reset;
    logic        read_request, write_request, flush_request;
    logic [3:0]  write_strobe;
    logic [31:0] addr, write_data;
    logic        response, flush_done;
    logic [31:0] read_data;
    logic        memory_read_request, memory_write_request, memory_response;
    logic [31:0] memory_addr, memory_read_data, memory_write_data;

    mem_op_t     log_q[$];
    mem_op_t     op;
    logic [31:0] mem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          both_seen = 0;
    int          wait_cnt = 0;
    logic [31:0] rd_val;
    int          edges;
    bit          ok;

    dcache_sa_wb #(.CACHE_SIZE(1024), .WAYS(2), .LINE_WORDS(4), .ADDR_WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .read_request(read_request),
        .write_request(write_request),
        .write_strobe(write_strobe),
        .addr(addr),
        .write_data(write_data),
        .response(response),
        .read_data(read_data),
        .flush_request(flush_request),
        .flush_done(flush_done),
        .memory_read_request(memory_read_request),
        .memory_write_request(memory_write_request),
        .memory_response(memory_response),
        .memory_addr(memory_addr),
        .memory_read_data(memory_read_data),
        .memory_write_data(memory_write_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a + 32'h1000_0000;
    endfunction

    // Memory answers each word two falling edges after the request appears.
    initial begin
        memory_response  = 1'b0;
        memory_read_data = '0;
        forever begin
            @(negedge clk);
            memory_response = 1'b0;
            if (memory_read_request && memory_write_request) both_seen++;
            if (reset && (memory_read_request || memory_write_request)) begin
                wait_cnt++;
                if (wait_cnt == 2) begin
                    wait_cnt = 0;
                    memory_response = 1'b1;
                    op.wr = memory_write_request;
                    op.a  = memory_addr;
                    if (memory_write_request) begin
                        mem[memory_addr] = memory_write_data;
                        op.d = memory_write_data;
                    end else begin
                        memory_read_data = mem_word(memory_addr);
                        op.d = memory_read_data;
                    end
                    log_q.push_back(op);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic cpu_access(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              output logic [31:0] rdata, output int n);
        log_q.delete();
        read_request  = rd;
        write_request = wr;
        addr          = a;
        write_data    = d;
        write_strobe  = s;
        rdata = '0;
        n = 0;
        while (1) begin
            @(posedge clk); #1;
            n++;
            if (response) begin
                rdata = read_data;
                break;
            end
            if (n >= 400) begin
                checks++; errors++;
                $display("FAIL access_timeout addr=%h got no response want response", a);
                break;
            end
        end
        read_request  = 1'b0;
        write_request = 1'b0;
    endtask

    task automatic do_flush(output int n, output bit done);
        log_q.delete();
        flush_request = 1'b1;
        n = 0;
        done = 1'b0;
        while (n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (flush_done) begin
                done = 1'b1;
                break;
            end
        end
        flush_request = 1'b0;
    endtask

    task test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({response, flush_done, memory_read_request, memory_write_request} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0000",
                     {response, flush_done, memory_read_request, memory_write_request});
        end
        checks++;
        if (read_data !== 32'h0) begin errors++; $display("FAIL reset_read_data got %h want 0", read_data); end
        checks++;
        if (memory_addr !== 32'h0 || memory_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_bus got %h/%h want 0/0", memory_addr, memory_write_data);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task test_read_miss_hit;
        cpu_access(1, 0, 32'h0, 32'h0, 4'h0, rd_val, edges);
        checks++;
        if (rd_val !== 32'h1000_0000) begin errors++; $display("FAIL t1_miss_data got %h want 10000000", rd_val); end
        checks++;
        if (log_q.size() != 4) begin errors++; $display("FAIL t1_refill_count got %0d want 4", log_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= log_q.size() || log_q[i].wr !== 1'b0 || log_q[i].a !== 32'(4 * i)) begin
                errors++;
                $display("FAIL t1_refill_word%0d got %h want read of %h", i, log_q[i].a, 4 * i);
            end
        end
        cpu_access(1, 0, 32'h4, 32'h0, 4'h0, rd_val, edges);
        checks++;
        if (rd_val !== 32'h1000_0004) begin errors++; $display("FAIL t1_hit_data got %h want 10000004", rd_val); end
        checks++;
        if (log_q.size() != 0) begin errors++; $display("FAIL t1_hit_traffic got %0d want 0", log_q.size()); end
        checks++;
        if (edges != 2) begin errors++; $display("FAIL t1_hit_latency got %0d want 2", edges); end
    endtask

    task test_write_allocate;
        cpu_access(0, 1, 32'h14, 32'h6A6A_6A6A, 4'b0011, rd_val, edges);
        checks++;
        if (log_q.size() != 4) begin errors++; $display("FAIL t2_refill_count got %0d want 4", log_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= log_q.size() || log_q[i].wr !== 1'b0 || log_q[i].a !== 32'(32'h10 + 4 * i)) begin
                errors++;
                $display("FAIL t2_refill_word%0d got %h want read of %h", i, log_q[i].a, 32'h10 + 4 * i);
            end
        end
        cpu_access(1, 0, 32'h14, 32'h0, 4'h0, rd_val, edges);
        checks++;
        if (rd_val !== 32'h1000_6A6A) begin errors++; $display("FAIL t2_merged got %h want 10006a6a", rd_val); end
    endtask

    task test_evict;
        cpu_access(1, 0, 32'h214, 32'h0, 4'h0, rd_val, edges);
        checks++;
        if (rd_val !== 32'h1000_0214) begin errors++; $display("FAIL t3_214_data got %h want 10000214", rd_val); end
        cpu_access(1, 0, 32'h414, 32'h0, 4'h0, rd_val, edges);
        checks++;
        if (rd_val !== 32'h1000_0414) begin errors++; $display("FAIL t3_414_data got %h want 10000414", rd_val); end
        checks++;
        if (log_q.size() != 8) begin errors++; $display("FAIL t3_evict_count got %0d want 8", log_q.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= log_q.size() || log_q[i].wr !== (i < 4) ||
                log_q[i].a !== ((i < 4) ? 32'(32'h10 + 4 * i) : 32'(32'h410 + 4 * (i - 4)))) begin
                errors++;
                $display("FAIL t3_evict_op%0d got wr=%0d a=%h want wr=%0d", i, log_q[i].wr, log_q[i].a, i < 4);
            end
        end
        checks++;
        if (log_q.size() < 2 || log_q[1].d !== 32'h1000_6A6A) begin
            errors++;
            $display("FAIL t3_wb_data got %h want 10006a6a", log_q[1].d);
        end
        cpu_access(1, 0, 32'h14, 32'h0, 4'h0, rd_val, edges);
        checks++;
        if (rd_val !== 32'h1000_6A6A) begin errors++; $display("FAIL t3_refetch got %h want 10006a6a", rd_val); end
        checks++;
        if (log_q.size() != 4 || log_q[0].wr !== 1'b0) begin
            errors++;
            $display("FAIL t3_refetch_traffic got %0d ops want 4 reads", log_q.size());
        end
    endtask

    task test_flush;
        cpu_access(0, 1, 32'h4, 32'h736F_6669, 4'b1111, rd_val, edges);
        checks++;
        if (edges != 2 || log_q.size() != 0) begin
            errors++;
            $display("FAIL t4_store_hit got %0d edges %0d ops want 2 edges 0 ops", edges, log_q.size());
        end
        do_flush(edges, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL t4_flush_done got no pulse want pulse"); end
        checks++;
        if (log_q.size() != 4) begin errors++; $display("FAIL t4_flush_count got %0d want 4", log_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= log_q.size() || log_q[i].wr !== 1'b1 || log_q[i].a !== 32'(4 * i)) begin
                errors++;
                $display("FAIL t4_flush_word%0d got %h want write of %h", i, log_q[i].a, 4 * i);
            end
        end
        checks++;
        if (log_q.size() < 2 || log_q[1].d !== 32'h736F_6669) begin
            errors++;
            $display("FAIL t4_flush_data got %h want 736f6669", log_q[1].d);
        end
        cpu_access(1, 0, 32'h4, 32'h0, 4'h0, rd_val, edges);
        checks++;
        if (rd_val !== 32'h736F_6669 || log_q.size() != 0) begin
            errors++;
            $display("FAIL t4_post_flush_read got %h ops=%0d want 736f6669 ops=0", rd_val, log_q.size());
        end
        do_flush(edges, ok);
        checks++;
        if (!ok || edges != 65) begin errors++; $display("FAIL t4_clean_flush_cycles got %0d want 65", edges); end
        checks++;
        if (log_q.size() != 0) begin errors++; $display("FAIL t4_clean_flush_traffic got %0d want 0", log_q.size()); end
    endtask

    task test_strobe_zero;
        cpu_access(0, 1, 32'h14, 32'hFFFF_FFFF, 4'b0000, rd_val, edges);
        checks++;
        if (edges != 2 || log_q.size() != 0) begin
            errors++;
            $display("FAIL s0_store got %0d edges %0d ops want 2 edges 0 ops", edges, log_q.size());
        end
        cpu_access(1, 0, 32'h14, 32'h0, 4'h0, rd_val, edges);
        checks++;
        if (rd_val !== 32'h1000_6A6A) begin errors++; $display("FAIL s0_data got %h want 10006a6a", rd_val); end
    endtask

    task test_read_write_collision;
        cpu_access(1, 1, 32'h8, 32'h55AA_55AA, 4'b1111, rd_val, edges);
        checks++;
        if (edges != 2) begin errors++; $display("FAIL t5_latency got %0d want 2", edges); end
        cpu_access(1, 0, 32'h8, 32'h0, 4'h0, rd_val, edges);
        checks++;
        if (rd_val !== 32'h55AA_55AA) begin errors++; $display("FAIL t5_stored got %h want 55aa55aa", rd_val); end
        do_flush(edges, ok);
        checks++;
        if (!ok || log_q.size() != 4) begin
            errors++;
            $display("FAIL t5_dirty_flush got %0d ops want 4", log_q.size());
        end
        checks++;
        if (log_q.size() < 3 || log_q[2].wr !== 1'b1 || log_q[2].a !== 32'h8 || log_q[2].d !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL t5_flush_word2 got %h=%h want 00000008=55aa55aa", log_q[2].a, log_q[2].d);
        end
    endtask

    task test_reset_abort;
        log_q.delete();
        read_request = 1'b1;
        addr = 32'h800;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (log_q.size() == 1 && memory_read_request) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL t6_second_word got no request want request"); end
        reset = 1'b0;
        read_request = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({memory_read_request, memory_write_request, response} !== 3'b000) begin
            errors++;
            $display("FAIL t6_abort got %b want 000", {memory_read_request, memory_write_request, response});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        cpu_access(1, 0, 32'h0, 32'h0, 4'h0, rd_val, edges);
        checks++;
        if (rd_val !== 32'h1000_0000 || log_q.size() != 4) begin
            errors++;
            $display("FAIL t6_refetch got %h ops=%0d want 10000000 ops=4", rd_val, log_q.size());
        end
    endtask

    initial begin
        reset = 1'b0;
        read_request = 1'b0;
        write_request = 1'b0;
        flush_request = 1'b0;
        write_strobe = 4'h0;
        addr = '0;
        write_data = '0;
        @(posedge clk); #1;
        test_reset();
        test_read_miss_hit();
        test_write_allocate();
        test_evict();
        test_flush();
        test_strobe_zero();
        test_read_write_collision();
        test_reset_abort();
        checks++;
        if (both_seen != 0) begin errors++; $display("FAIL mem_rw_together got %0d want 0", both_seen); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_sa_wb.md
Name: dcache_sa_wb

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache; successor to the current direct-mapped DCache.
- Sits between the core load/store unit and the word-wide Memory model, using the same request/response memory handshake.
- Adds over DCache: configurable associativity and line length, per-byte write strobes, dirty-line write-back on eviction, and an explicit flush operation.

Parameters:
CACHE_SIZE, 1024, total data capacity in bytes (power of 2)
WAYS, 2, associativity (1, 2 or 4)
LINE_WORDS, 4, 32-bit words per line (power of 2, ≥1)
ADDR_WIDTH, 32, byte address width
Derived: SETS = CACHE_SIZE / (4*LINE_WORDS*WAYS); offset = log2(4*LINE_WORDS) bits; index = log2(SETS) bits; remainder is tag.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
read_request  in  1  CPU load request, held until response
write_request  in  1  CPU store request, held until response
write_strobe  in  4  byte enables for a store (bit i → write_data[8i+7:8i])
addr  in  ADDR_WIDTH  CPU byte address; addr[1:0] ignored
write_data  in  32  store data
response  out  1  one-cycle completion pulse
read_data  out  32  load data, valid while response=1
flush_request  in  1  write back all dirty lines
flush_done  out  1  one-cycle pulse when flush completes
memory_read_request  out  1  word read to memory
memory_write_request  out  1  word write to memory
memory_response  in  1  memory completion, one cycle
memory_addr  out  ADDR_WIDTH  word-aligned memory address
memory_read_data  in  32  memory read data
memory_write_data  out  32  memory write data

Behaviour:
- Reset (reset=0 at an edge): all valid, dirty and victim bits are cleared; state=IDLE; response, flush_done, memory_read_request and memory_write_request are 0; read_data, memory_addr and memory_write_data are 0.
- Reset applied mid-operation aborts the operation immediately. Dirty data is discarded and memory requests drop the following cycle.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB.
- IDLE priority: flush_request > write_request > read_request. When both read and write are asserted, the access is a write. addr, write_data and write_strobe are registered when the request is accepted.
- LOOKUP: compare tags in all ways of the indexed set.
  - Hit: response=1 on the next edge, 2 edges after acceptance. Read returns the word; write merges bytes per strobe and sets dirty. Return to IDLE.
  - Miss: choose a victim — the lowest-index invalid way; otherwise the per-set round-robin pointer (log2(WAYS) bits), which increments on every refill of that set. Go to WRITEBACK if the victim is valid and dirty, else REFILL.
- WRITEBACK: write LINE_WORDS words at ascending addresses from the victim line base. Then clear dirty and go to REFILL.
- REFILL: read LINE_WORDS words from the requested line base; install tag and set valid; go to LOOKUP, which now hits. A store-miss completes as a hit, so dirty is set.
- Memory word handshake:
  - Hold request, address and data stable until memory_response=1; capture read data that same cycle.
  - Deassert the request for at least 1 cycle before the next word.
  - Read and write requests are never asserted together.
- Flush:
  - FLUSH_SCAN walks set 0..SETS-1, way 0..WAYS-1.
  - Each valid+dirty line is written back in FLUSH_WB, then its dirty bit is cleared. Valid is kept.
  - After the last line, flush_done=1 for one cycle and the FSM returns to IDLE.
  - A flush with no dirty lines completes in SETS*WAYS+1 cycles with no memory traffic.
- Requester deasserts its request in the cycle after response. A request still held in IDLE is treated as a new access.
- write_strobe=0000: the access completes (allocating on a miss) but does not change data or dirty state.

Decomposition:
- Package dcache_pkg:
  - state enum
  - helper functions for tag, index and offset field extraction from the parameters
  - line-base address function
- Sub-module dcache_way_store: one way's tag/valid/dirty/data arrays, instantiated WAYS times.
  - Write ports: line fill word, byte-strobed store, dirty clear.
  - Combinational read port with tag-match output.

Test Plan:
Configuration: CACHE_SIZE=1024, WAYS=2, LINE_WORDS=4. Memory word at byte address A holds A+32'h1000_0000.
1. Read 0x0 → 4 memory reads at 0x0, 0x4, 0x8, 0xC; response with read_data=0x1000_0000. Then read 0x4 → no memory traffic; response 2 edges after acceptance with 0x1000_0004.
2. Write 0x14, data 0x6A6A_6A6A, strobe 0011 → refill reads 0x10–0x1C, no memory write, response. Read 0x14 → 0x1000_6A6A.
3. Following 2: read 0x214, then 0x414 (both set 1) → the third line evicts the 0x10 line. Memory writes 0x10–0x1C, with 0x14 carrying 0x1000_6A6A, all before any refill read of 0x410. Read 0x14 → refetched 0x1000_6A6A.
4. Write 0x4, data 0x736F_6669, strobe 1111, then flush_request → exactly 1 line written (0x0–0xC, 0x4=0x736F_6669); flush_done pulse. Read 0x4 → hit, 0x736F_6669, no traffic. Second flush → no traffic, flush_done after 65 cycles.
5. read_request and write_request asserted together at 0x8 → treated as a write: data stored, dirty set, read_data not required.
6. reset=0 during the 2nd refill word → all requests low next cycle. After release, read 0x0 misses again and refetches 4 words.
